tlk_err_monitor: RTL and testbench
==================================

Name: tlk_err_monitor

Overview:
Per-link receive-quality monitor for the 18 TLK serial links on the OFC1 board. Watches each link's receive status (rx_dv, rx_er) over fixed time windows and decides whether the link is bad (tlk_err) for each window. Emits a one-cycle per-channel strobe (send_err) when a verdict must be reported. Its send_err/tlk_err outputs feed directly into the TLK error status register stage, which latches tlk_err[i] while send_err[i] is high.

Parameters:
NCH, 18, number of TLK links monitored
WIN_LEN, 1024, window length in clk cycles (>=4)
ERR_THR, 4, error cycles per window at or above which a link is declared bad (>=1)
CNT_W, 8, per-channel error counter width (saturating)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
live  input  1  run enable; low = monitoring halted, downstream status forced to all-error
rx_dv  input  NCH  per-link TLK receive data-valid, synchronous to clk
rx_er  input  NCH  per-link TLK receive error, synchronous to clk
send_err  output  NCH  per-channel one-cycle report strobe
tlk_err  output  NCH  per-channel verdict, 1 = link bad; valid whenever send_err[i]=1, held otherwise
win_done  output  1  one-cycle pulse coincident with any report cycle (for monitoring/debug)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, send_err=0, win_done=0, tlk_err=all 1s, counters=0, rx_dv-seen flags=0, first_rpt=1.
- FSM states: IDLE, ARM, ACCUM.
- IDLE: outputs send_err=0. live=1 -> ARM.
- ARM: one cycle. Clears win_cnt, err_cnt[*], dv_seen[*]; sets first_rpt=1. -> ACCUM.
- ACCUM: win_cnt counts 0..WIN_LEN-1, one count per cycle.
  - Each cycle, for each channel i: if rx_er[i]=1, err_cnt[i]++ (saturates at 2^CNT_W-1, no wrap). If rx_dv[i]=1, dv_seen[i]=1.
- Verdict: computed on the cycle win_cnt==WIN_LEN-1, including that cycle's inputs.
  - bad[i] = (err_cnt[i] >= ERR_THR) | ~dv_seen[i].
  - A link that shows no rx_dv for a whole window is bad.
- Report: registered on the next edge, so send_err is asserted for exactly one cycle, 1 cycle after the last window cycle.
  - send_err[i] = first_rpt | (bad[i] != tlk_err[i]).
  - tlk_err[i] <= bad[i].
  - win_done = 1.
  - first_rpt cleared after the first report.
- Window restart: the last window cycle also reloads the accumulators for the next window.
  - win_cnt=0.
  - err_cnt[i] and dv_seen[i] cleared.
  - Inputs in the cycle immediately after are counted in the new window. Windows are back-to-back with no gap; period = WIN_LEN cycles.
- live falls (sampled 0 in ARM or ACCUM):
  - Next state IDLE; partial window discarded; no report.
  - tlk_err <= all 1s; send_err=0.
- live re-rises: full ARM/ACCUM sequence again; the first report strobes all channels.
- rst has priority over live in every state.
- Simultaneous rx_er=1 and rx_dv=0: counts as an error cycle and does not set dv_seen.
- ERR_THR greater than the saturation value: a channel can never go bad on errors alone. This is a legal parameterisation; no special handling.

Optional Feature:
- Macro: TLK_ERR_CNT_EN.
- Defined: adds output err_cnt_bus (NCH*CNT_W bits).
  - Channel i occupies bits [i*CNT_W +: CNT_W].
  - Loaded with the final saturated err_cnt of every channel in the report cycle, simultaneously with send_err.
  - Held until the next report; reset to 0.
  - Cleared to 0 when live falls.
- Undefined: port and holding registers absent; all other behaviour identical.

Test Plan:
Bench parameters: NCH=18, WIN_LEN=16, ERR_THR=2, CNT_W=8.

1. Reset, live=1 (sampled at cycle 0 edge), rx_dv all 1, rx_er all 0 -> ARM at cycle 1; ACCUM window runs cycles 2..17; at cycle 18: send_err=0x3FFFF for 1 cycle, tlk_err=0x00000, win_done=1.
2. Continue clean links -> at cycles 34 and 50: win_done=1, send_err=0 (no change), tlk_err stays 0.
3. Ch5: rx_er=1 for 1 cycle in a window -> no strobe. Ch5: rx_er=1 for 2 cycles in the next window -> send_err=0x00020, tlk_err[5]=1. Following clean window -> send_err=0x00020, tlk_err[5]=0.
4. Ch17: rx_dv held 0 for a whole window -> send_err[17]=1, tlk_err[17]=1. rx_dv=1 on only the last cycle of the next window -> tlk_err[17] returns to 0.
5. Drop live mid-window (win_cnt=7) -> next cycle state IDLE, tlk_err=0x3FFFF, send_err=0. Raise live -> first report after 1+16 cycles strobes 0x3FFFF.
6. Assert rst in ACCUM with ch3 rx_er held 1 -> send_err=0, tlk_err=0x3FFFF, state IDLE. With TLK_ERR_CNT_EN: ch3 rx_er=1 for 300 cycles over WIN_LEN=512 -> err_cnt_bus[31:24]=8'hFF (saturated).

Source files
------------

// File: rtl/tlk_err_monitor.sv
// Per-link TLK receive-quality monitor: windowed error/data-valid accounting with change-only reports.
// Optional TLK_ERR_CNT_EN adds err_cnt_bus carrying each channel's final error count per report.
module tlk_err_monitor #(
    parameter int unsigned NCH     = 18,
    parameter int unsigned WIN_LEN = 1024,
    parameter int unsigned ERR_THR = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             live,
    input  logic [NCH-1:0]   rx_dv,
    input  logic [NCH-1:0]   rx_er,
    output logic [NCH-1:0]   send_err,
    output logic [NCH-1:0]   tlk_err,
`ifdef TLK_ERR_CNT_EN
    output logic [NCH*CNT_W-1:0] err_cnt_bus,
`endif
    output logic             win_done
);

    localparam int unsigned      WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StArm, StAccum} state_e;

    state_e                      state_q, state_d;
    logic [WIN_W-1:0]            win_cnt_q, win_cnt_d;
    logic [NCH-1:0][CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [NCH-1:0]              dv_seen_q, dv_seen_d;
    logic                        first_rpt_q, first_rpt_d;
    logic [NCH-1:0]              tlk_err_q, tlk_err_d;
    logic [NCH-1:0]              send_err_q, send_err_d;
    logic                        win_done_q, win_done_d;
`ifdef TLK_ERR_CNT_EN
    logic [NCH-1:0][CNT_W-1:0]   cnt_bus_q, cnt_bus_d;
`endif

    // Counts including the current cycle's inputs, so the verdict sees the last window cycle.
    logic [NCH-1:0][CNT_W-1:0]   err_acc;
    logic [NCH-1:0]              dv_acc;
    logic [NCH-1:0]              bad;

    always_comb begin
        dv_acc = dv_seen_q | rx_dv;
        for (int i = 0; i < NCH; i++) begin
            if (rx_er[i] && (err_cnt_q[i] != CNT_MAX)) begin
                err_acc[i] = err_cnt_q[i] + CNT_W'(1);
            end else begin
                err_acc[i] = err_cnt_q[i];
            end
            bad[i] = (32'(err_acc[i]) >= ERR_THR) || !dv_acc[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        err_cnt_d   = err_cnt_q;
        dv_seen_d   = dv_seen_q;
        first_rpt_d = first_rpt_q;
        tlk_err_d   = tlk_err_q;
        send_err_d  = '0;
        win_done_d  = 1'b0;
`ifdef TLK_ERR_CNT_EN
        cnt_bus_d   = cnt_bus_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (live) state_d = StArm;
            end
            StArm: begin
                win_cnt_d   = '0;
                err_cnt_d   = '0;
                dv_seen_d   = '0;
                first_rpt_d = 1'b1;
                state_d     = StAccum;
            end
            StAccum: begin
                if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d   = '0;
                    err_cnt_d   = '0;
                    dv_seen_d   = '0;
                    send_err_d  = {NCH{first_rpt_q}} | (bad ^ tlk_err_q);
                    tlk_err_d   = bad;
                    win_done_d  = 1'b1;
                    first_rpt_d = 1'b0;
`ifdef TLK_ERR_CNT_EN
                    cnt_bus_d   = err_acc;
`endif
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    err_cnt_d = err_acc;
                    dv_seen_d = dv_acc;
                end
            end
            default: state_d = StIdle;
        endcase

        // Halting discards the partial window and forces downstream status to all-error.
        if (!live && (state_q != StIdle)) begin
            state_d    = StIdle;
            tlk_err_d  = '1;
            send_err_d = '0;
            win_done_d = 1'b0;
`ifdef TLK_ERR_CNT_EN
            cnt_bus_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            win_cnt_q   <= '0;
            err_cnt_q   <= '0;
            dv_seen_q   <= '0;
            first_rpt_q <= 1'b1;
            tlk_err_q   <= '1;
            send_err_q  <= '0;
            win_done_q  <= 1'b0;
`ifdef TLK_ERR_CNT_EN
            cnt_bus_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            err_cnt_q   <= err_cnt_d;
            dv_seen_q   <= dv_seen_d;
            first_rpt_q <= first_rpt_d;
            tlk_err_q   <= tlk_err_d;
            send_err_q  <= send_err_d;
            win_done_q  <= win_done_d;
`ifdef TLK_ERR_CNT_EN
            cnt_bus_q   <= cnt_bus_d;
`endif
        end
    end

    assign send_err = send_err_q;
    assign tlk_err  = tlk_err_q;
    assign win_done = win_done_q;
`ifdef TLK_ERR_CNT_EN
    assign err_cnt_bus = cnt_bus_q;
`endif

endmodule

// File: tb/tb_tlk_err_monitor.sv
// Directed, table-driven bench for tlk_err_monitor: one vector per window plus live/rst sequences.
module tb_tlk_err_monitor;

    localparam int unsigned NCH     = 18;
    localparam int unsigned WIN_LEN = 16;
    localparam int unsigned ERR_THR = 2;
    localparam int unsigned CNT_W   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           live = 1'b0;
    logic [NCH-1:0] rx_dv = '1;
    logic [NCH-1:0] rx_er = '0;
    logic [NCH-1:0] send_err;
    logic [NCH-1:0] tlk_err;
    logic           win_done;
`ifdef TLK_ERR_CNT_EN
    logic [NCH*CNT_W-1:0] err_cnt_bus;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int cnt [NCH];

    tlk_err_monitor #(
        .NCH     (NCH),
        .WIN_LEN (WIN_LEN),
        .ERR_THR (ERR_THR),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .live        (live),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .send_err    (send_err),
        .tlk_err     (tlk_err),
`ifdef TLK_ERR_CNT_EN
        .err_cnt_bus (err_cnt_bus),
`endif
        .win_done    (win_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [NCH-1:0] er_mask;   // channels with rx_er for the first er_n cycles
        int             er_n;
        logic [NCH-1:0] er_last;   // channels with rx_er on the last window cycle
        logic [NCH-1:0] dv_off;    // channels with rx_dv low for the window
        logic [NCH-1:0] dv_last;   // channels with rx_dv high on the last cycle only
        logic [NCH-1:0] exp_send;
        logic [NCH-1:0] exp_tlk;
    } vec_t;

    vec_t vecs [12];
    vec_t clean_first;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drives one full window; the report is visible right after the final tick.
    task automatic run_window(input vec_t v);
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        for (int c = 0; c < int'(WIN_LEN); c++) begin
            rx_er = ((c < v.er_n) ? v.er_mask : '0) | ((c == int'(WIN_LEN) - 1) ? v.er_last : '0);
            rx_dv = ~v.dv_off | ((c == int'(WIN_LEN) - 1) ? v.dv_last : '0);
            for (int i = 0; i < NCH; i++) if (rx_er[i] && cnt[i] < 255) cnt[i]++;
            tick();
            if (c == 0) begin
                check({v.name, " send_err idle"}, 32'(send_err), 32'h0);
                check({v.name, " win_done idle"}, 32'(win_done), 32'h0);
            end
        end
        check({v.name, " send_err"}, 32'(send_err), 32'(v.exp_send));
        check({v.name, " tlk_err"},  32'(tlk_err),  32'(v.exp_tlk));
        check({v.name, " win_done"}, 32'(win_done), 32'h1);
`ifdef TLK_ERR_CNT_EN
        for (int i = 0; i < NCH; i++)
            check({v.name, " err_cnt_bus"}, 32'(err_cnt_bus[i*CNT_W +: CNT_W]), 32'(cnt[i]));
`endif
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{"clean first",   18'h0,  0, 18'h0, 18'h0,     18'h0,     18'h3FFFF, 18'h0};
        vecs[1]  = '{"clean 2",       18'h0,  0, 18'h0, 18'h0,     18'h0,     18'h0,     18'h0};
        vecs[2]  = '{"clean 3",       18'h0,  0, 18'h0, 18'h0,     18'h0,     18'h0,     18'h0};
        vecs[3]  = '{"ch5 er x1",     18'h20, 1, 18'h0, 18'h0,     18'h0,     18'h0,     18'h0};
        vecs[4]  = '{"ch5 er x2",     18'h20, 2, 18'h0, 18'h0,     18'h0,     18'h20,    18'h20};
        vecs[5]  = '{"ch5 recover",   18'h0,  0, 18'h0, 18'h0,     18'h0,     18'h20,    18'h0};
        vecs[6]  = '{"ch17 no dv",    18'h0,  0, 18'h0, 18'h20000, 18'h0,     18'h20000, 18'h20000};
        vecs[7]  = '{"ch17 dv last",  18'h0,  0, 18'h0, 18'h20000, 18'h20000, 18'h20000, 18'h0};
        vecs[8]  = '{"ch0-2 bad",     18'h5, 16, 18'h0, 18'h6,     18'h0,     18'h7,     18'h7};
        vecs[9]  = '{"ch0-2 recover", 18'h1,  1, 18'h0, 18'h0,     18'h0,     18'h7,     18'h0};
        vecs[10] = '{"ch3 er last",   18'h8,  1, 18'h8, 18'h0,     18'h0,     18'h8,     18'h8};
        vecs[11] = '{"ch3 cleared",   18'h0,  0, 18'h0, 18'h0,     18'h0,     18'h8,     18'h0};
        clean_first = vecs[0];

        // Reset with live already high: rst must win.
        rst = 1'b1; live = 1'b1; rx_dv = '1; rx_er = '0;
        repeat (3) tick();
        check("reset send_err", 32'(send_err), 32'h0);
        check("reset tlk_err",  32'(tlk_err),  32'h3FFFF);
        check("reset win_done", 32'(win_done), 32'h0);

        rst = 1'b0;
        tick();  // IDLE -> ARM
        tick();  // ARM -> ACCUM
        for (int k = 0; k < 12; k++) run_window(vecs[k]);

        // Drop live mid-window at win_cnt 7.
        rx_er = '0; rx_dv = '1;
        repeat (7) tick();
        live = 1'b0;
        tick();
        check("live drop send_err", 32'(send_err), 32'h0);
        check("live drop tlk_err",  32'(tlk_err),  32'h3FFFF);
        check("live drop win_done", 32'(win_done), 32'h0);
`ifdef TLK_ERR_CNT_EN
        check("live drop err_cnt_bus", 32'(|err_cnt_bus), 32'h0);
`endif
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | (|send_err) | win_done;
        end
        check("halted no report", 32'(seen), 32'h0);
        check("halted tlk_err", 32'(tlk_err), 32'h3FFFF);
        live = 1'b1;
        tick();
        tick();
        clean_first.name = "relive first";
        run_window(clean_first);

        // Reset in ACCUM with ch3 errors held.
        rx_er = 18'h8; rx_dv = '1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst accum send_err", 32'(send_err), 32'h0);
        check("rst accum tlk_err",  32'(tlk_err),  32'h3FFFF);
        check("rst accum win_done", 32'(win_done), 32'h0);
        tick();
        check("rst held send_err", 32'(send_err), 32'h0);
        rst = 1'b0; rx_er = '0;
        tick();
        tick();
        clean_first.name = "post-rst first";
        run_window(clean_first);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
